// File: rtl/trigger_pkg.sv
// trigger_pkg: shared definitions for the trigger sequence generator.
//   seq_state_e : FSM state encoding (also exported on seq_state for debug)
//   POL_*       : per-step polarity encoding of cfg_polarity bits
//   sat_sub     : unsigned subtract clamped at zero
package trigger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_STEP  = 3'd2,
    ST_DELAY = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam logic POL_FALL = 1'b0;
  localparam logic POL_RISE = 1'b1;

  // Operands are widened to SAT_W by the caller; counters up to 32 bits.
  localparam int SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/trigger_chan_cmp.sv
// trigger_chan_cmp: one sequence step's channel mux, mean register and
// threshold compare.
//   clk, rst_n  : clock, async active-low reset
//   clear       : synchronous clear of the mean register
//   adc_data    : all channels, {sample1, sample0} per 32-bit word
//   adc_enable  : per-channel mean update enable
//   ch_sel      : channel watched by this step
//   level       : signed level; compared against 2*level (mean is a sum)
//   polarity    : POL_RISE -> mean > 2*level, POL_FALL -> mean < 2*level
//   match       : strict compare result from the registered mean
module trigger_chan_cmp
  import trigger_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 16,
  parameter int N_CH           = 4,
  parameter int CH_W           = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [N_CH*32-1:0]        adc_data,
  input  logic [N_CH-1:0]           adc_enable,
  input  logic [CH_W-1:0]           ch_sel,
  input  logic [ADC_DATA_WIDTH-1:0] level,
  input  logic                      polarity,
  output logic                      match
);

  logic [31:0]                      word;
  logic                             en;
  logic [ADC_DATA_WIDTH-1:0]        s0, s1;
  logic signed [ADC_DATA_WIDTH:0]   mean_d, mean_q, thr;

  always_comb begin
    word   = adc_data[32*int'(ch_sel) +: 32];
    en     = adc_enable[ch_sel];
    s0     = word[ADC_DATA_WIDTH-1:0];
    s1     = word[16 +: ADC_DATA_WIDTH];
    // One extra bit so the sum of two full-scale samples cannot wrap.
    mean_d = {s0[ADC_DATA_WIDTH-1], s0} + {s1[ADC_DATA_WIDTH-1], s1};
    thr    = {level, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mean_q <= '0;
    end else if (clear) begin
      mean_q <= '0;
    end else if (en) begin
      mean_q <= mean_d;
    end
  end

  assign match = (polarity == POL_RISE) ? (mean_q > thr) : (mean_q < thr);

endmodule

// File: rtl/trigger_seq_gen.sv
// trigger_seq_gen: matches a programmable sequence of threshold crossings,
// fires trigger0 on the first step and trigger1 after a delay derived from
// the step0->step1 interval.
//   clk, rst_n        : clock, async active-low reset
//   adc_data          : N_CH x {sample1, sample0}
//   adc_enable        : per-channel mean update enable
//   trig_enable       : 0 = synchronous return to reset values, 1 = run
//   cfg_ch_sel        : channel per step
//   cfg_level         : signed level per step
//   cfg_polarity      : 1 = rising, 0 = falling, per step
//   cfg_delay_offset  : subtracted from the measured interval
//   cfg_timeout       : max clocks per step after step0 (0 = off)
//   cfg_auto_rearm    : on timeout go back to IDLE instead of DONE
//   trigger0/trigger1 : first-step / delayed final trigger
//   pulse_delay       : measured step0->step1 interval
//   fire_delay        : delay applied before trigger1
//   seq_state         : FSM state
//   timeout_flag      : sticky timeout
//   busy              : high in ARMED, STEP, DELAY
//
// state | meaning
// IDLE  | holdoff count-down after enable
// ARMED | waiting for step0
// STEP  | waiting for step k (1..N_STEPS-1), interval/timeout counting
// DELAY | down-counting fire_delay before trigger1
// DONE  | triggers held until trig_enable drops
module trigger_seq_gen
  import trigger_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 16,
  parameter int N_CH           = 4,
  parameter int N_STEPS        = 3,
  parameter int CNT_WIDTH      = 24,
  parameter int HOLDOFF        = 37000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_CH*32-1:0]                  adc_data,
  input  logic [N_CH-1:0]                     adc_enable,
  input  logic                                trig_enable,
  input  logic [N_STEPS*$clog2(N_CH)-1:0]     cfg_ch_sel,
  input  logic [N_STEPS*ADC_DATA_WIDTH-1:0]   cfg_level,
  input  logic [N_STEPS-1:0]                  cfg_polarity,
  input  logic [CNT_WIDTH-1:0]                cfg_delay_offset,
  input  logic [CNT_WIDTH-1:0]                cfg_timeout,
  input  logic                                cfg_auto_rearm,
  output logic                                trigger0,
  output logic                                trigger1,
  output logic [CNT_WIDTH-1:0]                pulse_delay,
  output logic [CNT_WIDTH-1:0]                fire_delay,
  output logic [2:0]                          seq_state,
  output logic                                timeout_flag,
  output logic                                busy
);

  localparam int CH_W = $clog2(N_CH);
  localparam int K_W  = $clog2(N_STEPS);
  localparam logic [CNT_WIDTH-1:0] HOLD_INIT = CNT_WIDTH'(HOLDOFF - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONES  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [K_W-1:0]       K_FIRST   = K_W'(1);
  localparam logic [K_W-1:0]       K_LAST    = K_W'(N_STEPS - 1);

  seq_state_e             state;
  logic [K_W-1:0]         k;
  logic [CNT_WIDTH-1:0]   hold_cnt, interval_cnt, step_cnt, dly_cnt;
  logic [CNT_WIDTH-1:0]   interval_inc, step_inc, pd_eff, fire_d;
  logic [N_STEPS-1:0]     step_match;
  logic [(1<<K_W)-1:0]    match_pad;
  logic                   k_match, timeout_hit;

  for (genvar i = 0; i < N_STEPS; i++) begin : g_step
    trigger_chan_cmp #(
      .ADC_DATA_WIDTH(ADC_DATA_WIDTH),
      .N_CH          (N_CH),
      .CH_W          (CH_W)
    ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (!trig_enable),
      .adc_data  (adc_data),
      .adc_enable(adc_enable),
      .ch_sel    (cfg_ch_sel[i*CH_W +: CH_W]),
      .level     (cfg_level[i*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]),
      .polarity  (cfg_polarity[i]),
      .match     (step_match[i])
    );
  end

  always_comb begin
    // Padded so a step index beyond N_STEPS-1 reads as "no match".
    match_pad                = '0;
    match_pad[N_STEPS-1:0]   = step_match;
    k_match                  = match_pad[k];
    interval_inc = (interval_cnt == CNT_ONES) ? interval_cnt : interval_cnt + CNT_ONE;
    step_inc     = (step_cnt == CNT_ONES) ? step_cnt : step_cnt + CNT_ONE;
    // With N_STEPS=2 the interval is latched on the same clock as the final
    // match, so the delay must use the fresh value rather than the register.
    pd_eff       = (k == K_FIRST) ? interval_inc : pulse_delay;
    fire_d       = CNT_WIDTH'(sat_sub(SAT_W'(pd_eff), SAT_W'(cfg_delay_offset)));
    timeout_hit  = (cfg_timeout != '0) && (step_inc == cfg_timeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      k            <= '0;
      hold_cnt     <= HOLD_INIT;
      interval_cnt <= '0;
      step_cnt     <= '0;
      dly_cnt      <= '0;
      trigger0     <= 1'b0;
      trigger1     <= 1'b0;
      pulse_delay  <= CNT_ONES;
      fire_delay   <= CNT_ONES;
      timeout_flag <= 1'b0;
    end else if (!trig_enable) begin
      state        <= ST_IDLE;
      k            <= '0;
      hold_cnt     <= HOLD_INIT;
      interval_cnt <= '0;
      step_cnt     <= '0;
      dly_cnt      <= '0;
      trigger0     <= 1'b0;
      trigger1     <= 1'b0;
      pulse_delay  <= CNT_ONES;
      fire_delay   <= CNT_ONES;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hold_cnt == '0) state <= ST_ARMED;
          else                hold_cnt <= hold_cnt - CNT_ONE;
        end
        ST_ARMED: begin
          if (step_match[0]) begin
            state        <= ST_STEP;
            k            <= K_FIRST;
            trigger0     <= 1'b1;
            interval_cnt <= '0;
            step_cnt     <= '0;
          end
        end
        ST_STEP: begin
          interval_cnt <= interval_inc;
          step_cnt     <= step_inc;
          if (k_match) begin
            step_cnt <= '0;
            if (k == K_FIRST) pulse_delay <= interval_inc;
            if (k == K_LAST) begin
              fire_delay <= fire_d;
              dly_cnt    <= fire_d;
              state      <= ST_DELAY;
            end else begin
              k <= k + K_W'(1);
            end
          end else if (timeout_hit) begin
            timeout_flag <= 1'b1;
            trigger0     <= 1'b0;
            if (cfg_auto_rearm) begin
              state    <= ST_IDLE;
              hold_cnt <= HOLD_INIT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DELAY: begin
          // A delay of 0 or 1 both fire on the first DELAY clock.
          if (dly_cnt <= CNT_ONE) begin
            trigger1 <= 1'b1;
            state    <= ST_DONE;
          end else begin
            dly_cnt <= dly_cnt - CNT_ONE;
          end
        end
        ST_DONE: ;
        default: begin
          state    <= ST_IDLE;
          hold_cnt <= HOLD_INIT;
        end
      endcase
    end
  end

  assign seq_state = state;
  assign busy      = (state == ST_ARMED) || (state == ST_STEP) || (state == ST_DELAY);

endmodule

// File: doc/trigger_seq_gen.md
Name: trigger_seq_gen

Overview:
Parametrised successor of the plasma-shot trigger generator. It watches N_CH ADC channels (two samples per clock) and matches a programmable sequence of N_STEPS threshold crossings. Each step has its own channel, level and polarity. The block measures the step0→step1 interval, asserts trigger0 on the first match, and asserts trigger1 after a delay derived from that interval. It adds per-step timeout and optional auto-rearm; it sits between the ADC interface and the trigger output/AXI register bank.

Parameters:
ADC_DATA_WIDTH, 16, sample width (two's complement, 14-bit ADC left in 16)
N_CH, 4, number of ADC channels
N_STEPS, 3, sequence length (legal range 2..8)
CNT_WIDTH, 24, width of interval/delay/timeout counters
HOLDOFF, 37000, idle clocks after enable before arming (8 ns clock)

Ports:
clk  in  1  125 MHz sample clock
rst_n  in  1  reset; asynchronous, active-low (already decided)
adc_data  in  N_CH*32  per channel {sample1, sample0}
adc_enable  in  N_CH  per-channel mean-register update enable
trig_enable  in  1  0 = synchronous soft reset to IDLE; 1 = run
cfg_ch_sel  in  N_STEPS*$clog2(N_CH)  channel for each step
cfg_level  in  N_STEPS*ADC_DATA_WIDTH  signed level for each step
cfg_polarity  in  N_STEPS  1 = rising (mean > 2·level), 0 = falling (mean < 2·level)
cfg_delay_offset  in  CNT_WIDTH  subtracted from the measured interval
cfg_timeout  in  CNT_WIDTH  max clocks per step after step0; 0 = disabled
cfg_auto_rearm  in  1  on timeout, return to IDLE holdoff automatically
trigger0  out  1  first-step trigger
trigger1  out  1  delayed final trigger
pulse_delay  out  CNT_WIDTH  measured step0→step1 interval
fire_delay  out  CNT_WIDTH  computed delay actually applied
seq_state  out  3  FSM state, for debug
timeout_flag  out  1  sticky timeout indication
busy  out  1  high in ARMED..DELAY

Behaviour:
- Reset (rst_n=0), async: state=IDLE, hold counter=HOLDOFF-1, triggers=0, pulse_delay and fire_delay all-ones, timeout_flag=0, means=0. trig_enable=0 applies the same values synchronously, and takes priority in any state.
- Mean: per channel, registered when adc_enable[i]=1; mean = sext(s0)+sext(s1), ADC_DATA_WIDTH+1 bits. Compare against {level,1'b0}, signed. Compares are strict: equality never matches.
- Latency: data sampled at edge N → mean valid after N → a match changes the FSM/outputs at edge N+1.
- States:
  - IDLE: hold counter decrements; at 0 → ARMED (HOLDOFF clocks in IDLE).
  - ARMED: step0 match → STEP, k=1, trigger0=1, interval counter=0.
  - STEP(k): interval and step-timeout counters +1 per clock, saturating at all-ones.
    - Step k match: timeout counter cleared. If k=1, latch pulse_delay = interval. If k=N_STEPS-1 → compute D, else k+1.
    - Timeout (cfg_timeout≠0 and step counter == cfg_timeout, no match that clock): timeout_flag=1; trigger0 cleared; → IDLE (reload holdoff) if cfg_auto_rearm, else DONE.
    - Match and timeout on the same clock: the match wins.
  - D = pulse_delay − cfg_delay_offset, saturating at 0; latched into fire_delay.
    - D=0: trigger1=1 on the clock after the final match → DONE.
    - Otherwise → DELAY, count D clocks, then trigger1=1 → DONE.
  - DONE: trigger0 and trigger1 held until trig_enable=0 or reset. No re-triggering.
- Config is sampled live. Software must change it only while trig_enable=0; other changes are undefined but must not lock the FSM.
- timeout_flag is cleared only by trig_enable=0 or reset.
- Undefined states → IDLE.

Decomposition:
- trigger_pkg: state encodings (IDLE, ARMED, STEP, DELAY, DONE), polarity constants, saturating-subtract function.
- Sub-module trigger_chan_cmp: mean register plus rising/falling compare for one step. Instantiated N_STEPS times, each with its own channel mux.

Test Plan:
- Holdoff: HOLDOFF=10, enable at t0 → seq_state=ARMED exactly 10 clocks later; a crossing earlier is ignored.
- Basic 3-step sequence (rising on ch0, level 1000):
  - Stimulus: ch0 samples 2000/2000; step1 ch1 crosses 50 clocks later; step2 ch2 crosses after; offset=20.
  - Required: trigger0 two edges after the data; pulse_delay=50; fire_delay=30; trigger1 30 clocks after the step2 match.
- Falling polarity and equality: level −500, mean exactly −1000 → no match; mean −1002 → match.
- Offset ≥ interval: pulse_delay=10, offset=40 → fire_delay=0, trigger1 on the next clock.
- Timeout: cfg_timeout=100, step1 never occurs → timeout_flag at clock 100, trigger0=0. With auto_rearm=1 → IDLE; with auto_rearm=0 → DONE.
- Async reset mid-DELAY and trig_enable drop in STEP → all outputs return to reset values, and the FSM re-arms after holdoff.
